// File: rtl/tnn_pkg.sv
// Shared types and helpers for the ternary-neuron popcount accumulator.
package tnn_pkg;

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_e;

    // Width needed to hold a count of 0..w.
    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Signed difference of two unsigned counts; callers truncate to the accumulator width.
    function automatic logic signed [31:0] cnt_delta(input logic [31:0] p, input logic [31:0] n);
        return $signed(p) - $signed(n);
    endfunction

endpackage

// File: rtl/tnn_popcount_w.sv
// Combinational popcount of a WIDTH-bit vector.
// With POPCOUNT_APPROX_EN defined, bit 0 is ignored (approximate-popcount library match).
module tnn_popcount_w
    import tnn_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]          bits,
    output logic [cnt_w(WIDTH)-1:0]   cnt
);

    localparam int unsigned CW = cnt_w(WIDTH);

`ifdef POPCOUNT_APPROX_EN
    localparam logic [WIDTH-1:0] EXCL_MASK = WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] EXCL_MASK = '0;
`endif

    logic [WIDTH-1:0] counted;
    assign counted = bits & ~EXCL_MASK;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt = cnt + CW'(counted[i]);
        end
    end

endmodule

// File: rtl/tnn_popcount_accum.sv
// Multi-beat ternary-neuron accumulator with valid/ready in and out.
// Build option: POPCOUNT_APPROX_EN selects the approximate per-beat popcount.
module tnn_popcount_accum
    import tnn_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned ACC_W     = $clog2(WIDTH * MAX_BEATS + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_pos,
    input  logic [WIDTH-1:0]        in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thresh,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_act,
    output logic                    out_ovf
);

    localparam int unsigned CW   = cnt_w(WIDTH);
    localparam int unsigned BC_W = $clog2(MAX_BEATS + 1);

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [BC_W-1:0]         beat_cnt_q;

    logic [WIDTH-1:0]        pos_eff, neg_eff;
    logic [CW-1:0]           pos_cnt, neg_cnt;
    logic signed [ACC_W-1:0] delta, sum_next;
    logic                    accept, last_beat;

    // A position set in both vectors carries weight 0.
    assign pos_eff = in_pos & ~in_neg;
    assign neg_eff = in_neg & ~in_pos;

    tnn_popcount_w #(.WIDTH(WIDTH)) u_cnt_pos (
        .bits (pos_eff),
        .cnt  (pos_cnt)
    );

    tnn_popcount_w #(.WIDTH(WIDTH)) u_cnt_neg (
        .bits (neg_eff),
        .cnt  (neg_cnt)
    );

    assign delta     = ACC_W'(cnt_delta(32'(pos_cnt), 32'(neg_cnt)));
    assign sum_next  = acc_q + delta;
    assign in_ready  = (state_q == S_ACC);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt_q == BC_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_act    <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            unique case (state_q)
                S_ACC: begin
                    if (accept) begin
                        acc_q      <= sum_next;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (in_last || last_beat) begin
                            state_q   <= S_OUT;
                            out_valid <= 1'b1;
                            out_sum   <= sum_next;
                            out_act   <= (sum_next >= thresh);
                            // Only reachable without in_last via the beat limit.
                            out_ovf   <= !in_last;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q    <= S_ACC;
                        out_valid  <= 1'b0;
                        acc_q      <= '0;
                        beat_cnt_q <= '0;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_tnn_popcount_accum.sv
// Directed self-checking bench for tnn_popcount_accum (WIDTH=8, MAX_BEATS=16).
module tb_tnn_popcount_accum;

`ifdef POPCOUNT_APPROX_EN
    localparam int APX = 1;
`else
    localparam int APX = 0;
`endif

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BEATS = 16;
    localparam int unsigned ACC_W     = $clog2(WIDTH * MAX_BEATS + 1) + 1;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_pos;
    logic [WIDTH-1:0]        in_neg;
    logic                    in_last;
    logic signed [ACC_W-1:0] thresh;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_act;
    logic                    out_ovf;

    int tests  = 0;
    int failed = 0;

    tnn_popcount_accum #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS),
        .ACC_W     (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_act   (out_act),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] p, input logic [7:0] n, input logic last);
        in_pos   = p;
        in_neg   = n;
        in_last  = last;
        in_valid = 1'b1;
        chk("beat_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_valid", out_valid, 0);
        chk("consume_ready", in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_neg    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        thresh    = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_act", out_act, 0);
        chk("rst_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Single full-positive beat
        thresh = 9'sd5;
        beat(8'hFF, 8'h00, 1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_sum", out_sum, 8 - APX);
        chk("single_act", out_act, 1);
        chk("single_ovf", out_ovf, 0);
        chk("single_in_ready", in_ready, 0);
        consume();

        // Three-beat negative sum
        thresh = 9'sd0;
        beat(8'h0F, 8'hF0, 1'b0);
        beat(8'h00, 8'hFF, 1'b0);
        chk("three_mid_valid", out_valid, 0);
        beat(8'h03, 8'h00, 1'b1);
        chk("three_valid", out_valid, 1);
        chk("three_sum", out_sum, -6 - APX);
        chk("three_act", out_act, 0);
        consume();

        // Full overlap counts nothing
        beat(8'hFF, 8'hFF, 1'b1);
        chk("overlap_sum", out_sum, 0);
        chk("overlap_act", out_act, 1);
        consume();

        // Threshold boundary: sum equal to threshold activates
        thresh = -9'sd6;
        beat(8'h00, 8'h3F, 1'b1);
        chk("eq_thr_sum", out_sum, -6 + APX);
        chk("eq_thr_act", out_act, 1);
        consume();

        // Truncation at MAX_BEATS
        thresh = 9'sd0;
        for (int i = 0; i < 15; i++) beat(8'h01, 8'h00, 1'b0);
        chk("trunc_15_valid", out_valid, 0);
        beat(8'h01, 8'h00, 1'b0);
        chk("trunc_valid", out_valid, 1);
        chk("trunc_sum", out_sum, 16 * (1 - APX));
        chk("trunc_ovf", out_ovf, 1);
        chk("trunc_act", out_act, 1);

        // Backpressure with the next neuron's beat already offered
        in_pos   = 8'h01;
        in_neg   = 8'h00;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 16 * (1 - APX));
            chk("bp_ovf", out_ovf, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("next_valid", out_valid, 1);
        chk("next_sum", out_sum, 1 - APX);
        chk("next_ovf", out_ovf, 0);
        consume();

        // Reset mid-stream discards partial sum
        beat(8'hFF, 8'h00, 1'b0);
        beat(8'hFF, 8'h00, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        beat(8'h01, 8'h00, 1'b1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", out_sum, 1 - APX);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
